// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory-side signals of mem_arbiter
// slave: the arbiter side; master: the clients plus the attached memory
interface mem_arbiter_if;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_ready;
    logic       if_done;
    logic [7:0] if_rdata;
    logic       if_err;
    logic       ls_req;
    logic       ls_we;
    logic [7:0] ls_addr;
    logic [7:0] ls_wdata;
    logic       ls_ready;
    logic       ls_done;
    logic [7:0] ls_rdata;
    logic       ls_err;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_write;
    logic [7:0] mem_data_out;
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        output if_ready, if_done, if_rdata, if_err,
        output ls_ready, ls_done, ls_rdata, ls_err,
        output mem_address, mem_data_in, mem_write
    );
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        input  if_ready, if_done, if_rdata, if_err,
        input  ls_ready, ls_done, ls_rdata, ls_err,
        input  mem_address, mem_data_in, mem_write
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a load/store port onto one registered byte memory
// Ports: clock; reset (async, active-high); bus (mem_arbiter_if.slave) with the fetch
// request/response, the load/store request/response and the registered memory interface.
module mem_arbiter #(
    parameter int unsigned MEM_DEPTH = 128
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ERR} state_t;
    state_t     state;
    state_t     state_nxt;
    logic       last_ls;
    logic       cur_ls;
    logic       cur_we;
    logic       grant_ls;
    logic       grant_if;
    logic       accept;
    logic       in_range;
    logic [7:0] acc_addr;
    // on a tie, the port that lost the previous acceptance wins
    assign grant_ls      = bus.ls_req & (~bus.if_req | ~last_ls);
    assign grant_if      = bus.if_req & ~grant_ls;
    assign bus.ls_ready  = (state == IDLE) & grant_ls;
    assign bus.if_ready  = (state == IDLE) & grant_if;
    assign accept        = bus.ls_ready | bus.if_ready;
    assign acc_addr      = grant_ls ? bus.ls_addr : bus.if_addr;
    assign in_range      = 32'(acc_addr) < MEM_DEPTH;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    // every completing state returns to IDLE on the same edge that raises done
    always_comb begin
        state_nxt = (state == IDLE) ? (accept ? (in_range ? ISSUE : ERR) : IDLE) :
                    (state == ISSUE && !cur_we) ? CAPTURE : IDLE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_ls         <= 1'b0;
            cur_ls          <= 1'b0;
            cur_we          <= 1'b0;
            bus.if_done     <= 1'b0;
            bus.if_err      <= 1'b0;
            bus.if_rdata    <= 8'h00;
            bus.ls_done     <= 1'b0;
            bus.ls_err      <= 1'b0;
            bus.ls_rdata    <= 8'h00;
            bus.mem_address <= 8'h00;
            bus.mem_data_in <= 8'h00;
            bus.mem_write   <= 1'b0;
        end else begin
            bus.if_done   <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.ls_done   <= 1'b0;
            bus.ls_err    <= 1'b0;
            bus.mem_write <= 1'b0;
            if (accept) begin
                last_ls <= grant_ls;
                cur_ls  <= grant_ls;
                cur_we  <= grant_ls & bus.ls_we;
                // out-of-range accesses never reach the memory pins
                if (in_range) begin
                    bus.mem_address <= acc_addr;
                    bus.mem_data_in <= grant_ls ? bus.ls_wdata : 8'h00;
                    bus.mem_write   <= grant_ls & bus.ls_we;
                end
            end
            if (state == ISSUE && cur_we)
                bus.ls_done <= 1'b1;
            if (state == CAPTURE || state == ERR) begin
                if (cur_ls) begin
                    bus.ls_done  <= 1'b1;
                    bus.ls_err   <= state == ERR;
                    bus.ls_rdata <= (state == ERR) ? 8'h00 : bus.mem_data_out;
                end else begin
                    bus.if_done  <= 1'b1;
                    bus.if_err   <= state == ERR;
                    bus.if_rdata <= (state == ERR) ? 8'h00 : bus.mem_data_out;
                end
            end
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_DEPTH, 128, number of valid byte addresses in the attached memory; addresses >= MEM_DEPTH are out of range.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request, valid for the current cycle.
REQ-005 if_addr  input  8  fetch byte address.
REQ-006 if_ready  output  1  fetch request accepted this cycle when if_req and if_ready are both high.
REQ-007 if_done  output  1  one-cycle fetch completion strobe.
REQ-008 if_rdata  output  8  fetched byte, valid while if_done is high.
REQ-009 if_err  output  1  out-of-range flag, valid while if_done is high.
REQ-010 ls_req  input  1  load/store request.
REQ-011 ls_we  input  1  1 = store, 0 = load.
REQ-012 ls_addr  input  8  load/store byte address.
REQ-013 ls_wdata  input  8  store data.
REQ-014 ls_ready, ls_done, ls_rdata[7:0], ls_err  outputs  1/1/8/1  same meaning as the fetch equivalents, for the load/store port.
REQ-015 mem_address  output  8  registered address to the memory.
REQ-016 mem_data_in  output  8  registered write data to the memory.
REQ-017 mem_write  output  1  registered write enable to the memory.
REQ-018 mem_data_out  input  8  memory read data, valid one clock edge after the address is presented with mem_write=0.

Function
REQ-019 FSM states: IDLE, ISSUE, CAPTURE, ERR; the arbiter handles one transaction at a time.
REQ-020 if_ready = IDLE & grant_if.
REQ-021 ls_ready = IDLE & grant_ls.
REQ-022 Arbitration, when only one port requests: that port is granted.
REQ-023 Arbitration, when both ports request: the port not granted in the last accepted transaction is granted.
REQ-024 last_grant updates on every acceptance; its reset value is IF, so the first tie goes to LS.
REQ-025 Outside IDLE, both ready outputs are 0 and requests are ignored; there is no queuing.
REQ-026 Acceptance at edge E0 latches port, address, data and we.
REQ-027 In-range acceptance: mem_address <= addr; mem_data_in <= wdata (0 for fetch); mem_write <= we (0 for fetch); go to ISSUE.
REQ-028 Out-of-range acceptance (addr >= MEM_DEPTH): mem_write stays 0; go to ERR.
REQ-029 ISSUE, store, at E1: mem_write <= 0; ls_done <= 1; go to IDLE.
REQ-030 ISSUE, read, at E1: mem_write stays 0; go to CAPTURE.
REQ-031 CAPTURE at E2: <port>_rdata <= mem_data_out; <port>_done <= 1; go to IDLE.
REQ-032 ERR at E1: <port>_done <= 1; <port>_err <= 1; <port>_rdata <= 8'h00; go to IDLE.
REQ-033 Done and err are single-cycle pulses; rdata holds its value until the next read completion on that port.
REQ-034 Latency: store and error done appear 1 cycle after acceptance; read done appears 2 cycles after acceptance.
REQ-035 IDLE is re-entered in the same edge that raises done, so a new request can be accepted in the done cycle (back-to-back throughput: one read per 3 cycles, one store per 2).
REQ-036 mem_write is high for exactly one cycle per store and never high for fetches or out-of-range accesses.

Reset
REQ-037 Reset asserts asynchronously: state=IDLE, last_grant=IF, all done/err=0, all rdata=0, mem_address=0, mem_data_in=0, mem_write=0.
REQ-038 Reset mid-transaction aborts it: no done is produced, and mem_write falls immediately without waiting for a clock.
REQ-039 The first acceptance is possible at the first posedge after reset deasserts.

Verification
REQ-040 Fetch read: memory[0x05]=0xA7, if_req=1, if_addr=0x05 -> mem_address=0x05 at ISSUE; if_done=1 and if_rdata=0xA7 exactly 2 cycles after acceptance; if_err=0.
REQ-041 Store then load: store ls_addr=0x10, ls_wdata=0x3C -> mem_write high for 1 cycle and ls_done after 1 cycle; then load 0x10 -> ls_rdata=0x3C.
REQ-042 Tie fairness: if_req and ls_req held high together for 4 transactions -> grants are LS, IF, LS, IF, with the non-granted ready=0 each time.
REQ-043 Out of range: ls_we=1, ls_addr=0x80 -> mem_write never rises; 1 cycle after acceptance ls_done=1, ls_err=1, ls_rdata=0x00.
REQ-044 Reset during a store in ISSUE -> mem_write=0 without a clock edge; no ls_done; ready=1 after release.
REQ-045 Back-to-back: a new ls_req presented in the cycle ls_done is high -> accepted in that cycle (ls_ready=1).
